// File: rtl/simple_mem_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package simple_mem_pkg;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;
  localparam int unsigned WAIT_W        = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    REQ_IF   = 1'b0,
    REQ_DATA = 1'b1
  } requester_e;

  // Request payload as seen after the arbitration mux
  typedef struct packed {
    logic [XLEN-1:0]       addr;
    logic                  we;
    logic [WORD_BYTES-1:0] be;
    logic [XLEN-1:0]       wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; on a tie the requester that did not win last time is chosen.
module rr_arbiter2
  import simple_mem_pkg::*;
(
  input  logic [1:0] req,
  input  requester_e last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_DATA) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/simple_mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store,
// one request at a time, with wait states and per-requester response pulses.
module simple_mem_arbiter
  import simple_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WAIT_CYCLES = 0,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [XLEN-1:0]       if_req_addr,
  output logic                  if_rsp_valid,
  output logic [XLEN-1:0]       if_rsp_data,
  output logic                  if_rsp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [XLEN-1:0]       d_req_addr,
  input  logic                  d_req_we,
  input  logic [WORD_BYTES-1:0] d_req_be,
  input  logic [XLEN-1:0]       d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [XLEN-1:0]       d_rsp_data,
  output logic                  d_rsp_err,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [WORD_BYTES-1:0] mem_be,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);

  state_e                state_q, state_d;
  requester_e            last_grant_q, last_grant_d;
  requester_e            id_q, id_d, gnt_id;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic                  we_q, we_d;
  logic [WORD_BYTES-1:0] be_q, be_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;

  logic [1:0] grant;
  mem_req_t   sel;
  logic       hs;
  logic       bad_addr;
  logic       last_beat;

  logic                  mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]     mem_addr_n;
  logic [WORD_BYTES-1:0] mem_be_n;
  logic [XLEN-1:0]       mem_wdata_n;
  logic                  if_rsp_valid_n, if_rsp_err_n;
  logic [XLEN-1:0]       if_rsp_data_n;
  logic                  d_rsp_valid_n, d_rsp_err_n;
  logic [XLEN-1:0]       d_rsp_data_n;
  logic [XLEN-1:0]       rdata_c;

  rr_arbiter2 u_arb (
    .req        ({d_req_valid, if_req_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign gnt_id    = grant[1] ? REQ_DATA : REQ_IF;
  assign hs        = (state_q == IDLE) && (grant != 2'b00);
  assign last_beat = (cnt_q == WAIT_W'(WAIT_CYCLES));

  // Ready is combinational in IDLE and forced low while reset is held
  assign if_req_ready = !rst && hs && grant[0];
  assign d_req_ready  = !rst && hs && grant[1];

  always_comb begin
    sel = '{addr: d_req_addr, we: d_req_we, be: d_req_be, wdata: d_req_wdata};
    if (gnt_id == REQ_IF) begin
      sel = '{addr: if_req_addr, we: 1'b0, be: '0, wdata: '0};
    end
  end

  assign bad_addr = (sel.addr[1:0] != 2'b00) ||
                    (sel.addr[XLEN-1:2] >= (XLEN-2)'(DEPTH));

  // State register, latched request and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_DATA;
      id_q         <= REQ_IF;
      waddr_q      <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      d_rsp_valid  <= 1'b0;
      d_rsp_data   <= '0;
      d_rsp_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      waddr_q      <= waddr_d;
      we_q         <= we_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      mem_en       <= mem_en_n;
      mem_addr     <= mem_addr_n;
      mem_we       <= mem_we_n;
      mem_be       <= mem_be_n;
      mem_wdata    <= mem_wdata_n;
      if_rsp_valid <= if_rsp_valid_n;
      if_rsp_data  <= if_rsp_data_n;
      if_rsp_err   <= if_rsp_err_n;
      d_rsp_valid  <= d_rsp_valid_n;
      d_rsp_data   <= d_rsp_data_n;
      d_rsp_err    <= d_rsp_err_n;
    end
  end

  // Next state and request latch
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    waddr_d      = waddr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          waddr_d      = sel.addr[ADDR_W+1:2];
          we_d         = sel.we;
          be_d         = sel.be;
          wdata_d      = sel.wdata;
          err_d        = bad_addr;
          cnt_d        = '0;
          state_d      = bad_addr ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (last_beat) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    mem_en_n       = 1'b0;
    mem_addr_n     = '0;
    mem_we_n       = 1'b0;
    mem_be_n       = '0;
    mem_wdata_n    = '0;
    if_rsp_valid_n = 1'b0;
    if_rsp_data_n  = '0;
    if_rsp_err_n   = 1'b0;
    d_rsp_valid_n  = 1'b0;
    d_rsp_data_n   = '0;
    d_rsp_err_n    = 1'b0;
    rdata_c        = (state_q == ACCESS && !we_q) ? mem_rdata : '0;
    if (state_d == ACCESS) begin
      mem_en_n    = 1'b1;
      mem_addr_n  = waddr_d;
      mem_be_n    = be_d;
      mem_wdata_n = wdata_d;
      mem_we_n    = we_d && (cnt_d == WAIT_W'(WAIT_CYCLES));
    end
    if (state_d == RESP) begin
      if (id_d == REQ_IF) begin
        if_rsp_valid_n = 1'b1;
        if_rsp_data_n  = rdata_c;
        if_rsp_err_n   = err_d;
      end else begin
        d_rsp_valid_n = 1'b1;
        d_rsp_data_n  = rdata_c;
        d_rsp_err_n   = err_d;
      end
    end
  end

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Bench for simple_mem_arbiter: two instances (WAIT_CYCLES 0 and 2) driven one at a time,
// checked every cycle against a transaction-schedule model plus directed literal checks.
module tb_simple_mem_arbiter;

  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_view_t;

  typedef struct packed {
    logic        if_v;
    logic [31:0] if_d;
    logic        if_e;
    logic        d_v;
    logic [31:0] d_d;
    logic        d_e;
  } rsp_view_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel;
  logic        if_req_valid, d_req_valid, d_req_we;
  logic [31:0] if_req_addr, d_req_addr, d_req_wdata;
  logic [3:0]  d_req_be;

  logic        if_rdy_a[2], if_v_a[2], if_e_a[2], d_rdy_a[2], d_v_a[2], d_e_a[2];
  logic        en_a[2], we_a[2];
  logic [31:0] if_d_a[2], d_d_a[2], wd_a[2];
  logic [4:0]  ad_a[2];
  logic [3:0]  be_a[2];
  logic [31:0] mem[DEPTH];
  logic [31:0] mref[DEPTH];

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    simple_mem_arbiter #(.DEPTH(DEPTH), .WAIT_CYCLES(2 * g)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_valid (if_req_valid && (sel == 1'(g))),
      .if_req_ready (if_rdy_a[g]),
      .if_req_addr  (if_req_addr),
      .if_rsp_valid (if_v_a[g]),
      .if_rsp_data  (if_d_a[g]),
      .if_rsp_err   (if_e_a[g]),
      .d_req_valid  (d_req_valid && (sel == 1'(g))),
      .d_req_ready  (d_rdy_a[g]),
      .d_req_addr   (d_req_addr),
      .d_req_we     (d_req_we),
      .d_req_be     (d_req_be),
      .d_req_wdata  (d_req_wdata),
      .d_rsp_valid  (d_v_a[g]),
      .d_rsp_data   (d_d_a[g]),
      .d_rsp_err    (d_e_a[g]),
      .mem_en       (en_a[g]),
      .mem_addr     (ad_a[g]),
      .mem_we       (we_a[g]),
      .mem_be       (be_a[g]),
      .mem_wdata    (wd_a[g]),
      .mem_rdata    (mem[ad_a[g]])
    );
  end

  // View of whichever instance is currently selected
  logic      v_if_rdy, v_d_rdy;
  mem_view_t v_mem;
  rsp_view_t v_rsp;
  always_comb begin
    v_if_rdy = if_rdy_a[sel];
    v_d_rdy  = d_rdy_a[sel];
    v_mem    = '{en: en_a[sel], addr: ad_a[sel], we: we_a[sel], be: be_a[sel], wdata: wd_a[sel]};
    v_rsp    = '{if_v: if_v_a[sel], if_d: if_d_a[sel], if_e: if_e_a[sel],
                 d_v: d_v_a[sel], d_d: d_d_a[sel], d_e: d_e_a[sel]};
  end

  // Single-port memory with byte-enabled writes
  always @(posedge clk) begin
    if (v_mem.we) begin
      for (int b = 0; b < 4; b++) begin
        if (v_mem.be[b]) mem[v_mem.addr][8*b +: 8] <= v_mem.wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: on each accepted request, schedule the expected outputs of the following cycles
  mem_view_t fut_m[8];
  rsp_view_t fut_r[8];
  int        busy = 0;
  bit        last_data[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin : model
    bit          win_if, win_d, st;
    int          w;
    logic [31:0] a, word;
    if (rst) begin
      busy = 0;
      last_data[0] = 1'b1;
      last_data[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        fut_m[i] = '0;
        fut_r[i] = '0;
      end
    end else begin
      w = sel ? 2 : 0;
      chk("mem_port", 128'(v_mem), 128'(fut_m[0]));
      chk("rsp_port", 128'(v_rsp), 128'(fut_r[0]));
      win_if = 1'b0;
      win_d  = 1'b0;
      if (busy == 0) begin
        if (if_req_valid && d_req_valid) begin
          win_if = last_data[sel];
          win_d  = !last_data[sel];
        end else begin
          win_if = if_req_valid;
          win_d  = d_req_valid;
        end
      end
      chk("ready", 128'({v_if_rdy, v_d_rdy}), 128'({win_if, win_d}));
      if (win_if || win_d) begin
        last_data[sel] = win_d;
        a    = win_d ? d_req_addr : if_req_addr;
        word = a >> 2;
        st   = win_d && d_req_we;
        if (a[1:0] != 2'b00 || word >= DEPTH) begin
          if (win_d) begin
            fut_r[1].d_v = 1'b1;
            fut_r[1].d_e = 1'b1;
          end else begin
            fut_r[1].if_v = 1'b1;
            fut_r[1].if_e = 1'b1;
          end
          busy = 2;
        end else begin
          for (int i = 1; i <= w + 1; i++) begin
            fut_m[i] = '{en: 1'b1, addr: word[4:0], we: st && (i == w + 1),
                         be: win_d ? d_req_be : 4'h0, wdata: win_d ? d_req_wdata : 32'h0};
          end
          if (win_d) begin
            fut_r[w+2].d_v = 1'b1;
            fut_r[w+2].d_d = st ? 32'h0 : mref[word[4:0]];
          end else begin
            fut_r[w+2].if_v = 1'b1;
            fut_r[w+2].if_d = mref[word[4:0]];
          end
          if (st) begin
            for (int b = 0; b < 4; b++) begin
              if (d_req_be[b]) mref[word[4:0]][8*b +: 8] = d_req_wdata[8*b +: 8];
            end
          end
          busy = w + 3;
        end
      end
      for (int i = 0; i < 7; i++) begin
        fut_m[i] = fut_m[i+1];
        fut_r[i] = fut_r[i+1];
      end
      fut_m[7] = '0;
      fut_r[7] = '0;
      if (busy > 0) busy--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One request held for a single accepted cycle; returns in the cycle after the handshake
  task automatic one_req(string name, bit is_d, logic [31:0] addr, bit we,
                         logic [3:0] be, logic [31:0] wd);
    step();
    if_req_valid = !is_d;
    if_req_addr  = addr;
    d_req_valid  = is_d;
    d_req_addr   = addr;
    d_req_we     = we;
    d_req_be     = be;
    d_req_wdata  = wd;
    sample();
    chk(name, 128'({v_if_rdy, v_d_rdy}), 128'({!is_d, is_d}));
    step();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
  endtask

  bit [1:0] exp_g[3] = '{2'b10, 2'b01, 2'b10};

  initial begin
    sel = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_be = '0; d_req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = 32'h1000_0000 + i;
      mref[i] = 32'h1000_0000 + i;
    end
    mem[2] = 32'h00A0_0093; mref[2] = 32'h00A0_0093;
    mem[3] = 32'h1122_3344; mref[3] = 32'h1122_3344;

    #2;
    chk("reset_state", 128'({v_mem, v_rsp, v_if_rdy, v_d_rdy}), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Fetch only, no wait states
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h8;
    sample();
    chk("t1_ready", 128'(v_if_rdy), 128'(1));
    step();
    if_req_valid = 1'b0;
    sample();
    chk("t1_mem_addr", 128'({v_mem.en, v_mem.addr}), 128'({1'b1, 5'd2}));
    step();
    sample();
    chk("t1_rsp", 128'({v_rsp.if_v, v_rsp.if_d, v_rsp.if_e, v_rsp.d_v}),
        128'({1'b1, 32'h00A0_0093, 1'b0, 1'b0}));
    step();

    // Three ties on the 2-wait instance; the loser withdraws each time
    sel = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step();
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0; d_req_be = 4'h0;
      sample();
      chk($sformatf("t2_grant%0d", r), 128'({v_if_rdy, v_d_rdy}), 128'(exp_g[r]));
      step();
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      repeat (5) begin sample(); step(); end
    end

    // Store with two wait states
    one_req("t3_ready", 1'b1, 32'hC, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    for (int i = 1; i <= 3; i++) begin
      sample();
      chk($sformatf("t3_access%0d", i), 128'({v_mem.en, v_mem.we, v_mem.addr}),
          128'({1'b1, i == 3, 5'd3}));
      step();
    end
    sample();
    chk("t3_rsp", 128'({v_rsp.d_v, v_rsp.d_d, v_rsp.d_e, v_mem.en}), 128'({1'b1, 32'h0, 1'b0, 1'b0}));
    step();
    chk("t3_mem", 128'(mem[3]), 128'(32'h1122_BEEF));
    one_req("t3_load_ready", 1'b1, 32'hC, 1'b0, 4'h0, 32'h0);
    repeat (3) begin sample(); step(); end
    sample();
    chk("t3_load", 128'({v_rsp.d_v, v_rsp.d_d}), 128'({1'b1, 32'h1122_BEEF}));
    step();

    // Error responses and boundary store on the no-wait instance
    sel = 1'b0;
    one_req("t4_fetch_ready", 1'b0, 32'h6, 1'b0, 4'h0, 32'h0);
    sample();
    chk("t4_fetch_err", 128'({v_rsp.if_v, v_rsp.if_e, v_rsp.if_d, v_mem.en}), 128'({2'b11, 32'h0, 1'b0}));
    step();
    one_req("t4_load_ready", 1'b1, 32'h80, 1'b0, 4'h0, 32'h0);
    sample();
    chk("t4_load_err", 128'({v_rsp.d_v, v_rsp.d_e, v_rsp.d_d, v_mem.en}), 128'({2'b11, 32'h0, 1'b0}));
    step();
    one_req("t4_store_ready", 1'b1, 32'h80, 1'b1, 4'hF, 32'h1234_5678);
    sample();
    chk("t4_store_err", 128'({v_rsp.d_v, v_rsp.d_e, v_mem.en}), 128'(3'b110));
    step();
    one_req("t4_top_ready", 1'b1, 32'h7C, 1'b1, 4'hF, 32'hCAFE_F00D);
    sample();
    chk("t4_top_access", 128'({v_mem.en, v_mem.we, v_mem.addr}), 128'({2'b11, 5'd31}));
    step();
    sample();
    chk("t4_top_rsp", 128'({v_rsp.d_v, v_rsp.d_e}), 128'(2'b10));
    step();
    chk("t4_top_mem", 128'(mem[31]), 128'(32'hCAFE_F00D));

    // Reset during the access phase of a load
    sel = 1'b1;
    one_req("t5_ready", 1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
    sample();
    chk("t5_in_access", 128'({v_mem.en, v_mem.addr}), 128'({1'b1, 5'd4}));
    #1 rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h4;
    #1;
    chk("t5_async_zero", 128'({v_mem, v_rsp, v_if_rdy, v_d_rdy}), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    sample();
    chk("t5_tie_after_reset", 128'({v_if_rdy, v_d_rdy}), 128'(2'b10));
    step();
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk($sformatf("t5_no_d_rsp%0d", i), 128'(v_rsp.d_v), 128'(0));
      step();
    end

    // Withdrawn data request while fetch is being serviced
    sel = 1'b0;
    one_req("t6_fetch_ready", 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0;
    sample();
    chk("t6_withdrawn_ready", 128'(v_d_rdy), 128'(0));
    step();
    d_req_valid = 1'b0;
    sample();
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h4;
    sample();
    chk("t6_tie", 128'({v_if_rdy, v_d_rdy}), 128'(2'b01));
    step();
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (4) begin sample(); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
